// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width default and FSM state encoding for the shift/subtract divider
package div_pkg;

   localparam int DIV_WIDTH = 8;

   typedef logic [1:0] div_state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_ITER = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/shift_sub_divider_if.sv
// rtl/shift_sub_divider_if.sv - request/result bundle between a requester and shift_sub_divider
interface shift_sub_divider_if
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/start_pulse.sv
// rtl/start_pulse.sv - rising-edge detector for start, used when DIV_START_EDGE_EN is defined
module start_pulse (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic level,
   output logic pulse
);
   logic level_prev;

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) level_prev <= 1'b0;
      else       level_prev <= level;
   end

   assign pulse = level & ~level_prev;
endmodule

// File: rtl/shift_sub_divider.sv
// rtl/shift_sub_divider.sv - restoring shift/subtract unsigned divider, one quotient bit per cycle
// DIV_START_EDGE_EN: accept start on its rising edge instead of its level
module shift_sub_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input logic                clk_100MHz,
   input logic                reset_butt,
   shift_sub_divider_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   div_state_t       state;
   logic [WIDTH-1:0] dvd_q;   // dividend bits shift out the top while quotient bits shift in below
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH:0]   rem_q;
   logic [CW-1:0]    cnt_q;
   logic             start_acc;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_nx;
   logic             q_bit;

`ifdef DIV_START_EDGE_EN
   start_pulse u_start_pulse (
      .clk_100MHz(clk_100MHz),
      .reset     (reset_butt),
      .level     (bus.start),
      .pulse     (start_acc)
   );
`else
   assign start_acc = bus.start;
`endif

   always_comb begin
      rem_sh = (WIDTH+1)'({rem_q, dvd_q[WIDTH-1]});
      q_bit  = (rem_sh >= {1'b0, dsr_q});
      rem_nx = q_bit ? (rem_sh - {1'b0, dsr_q}) : rem_sh;
   end

   always_ff @(posedge clk_100MHz or posedge reset_butt) begin
      if (reset_butt) begin
         state           <= ST_IDLE;
         dvd_q           <= '0;
         dsr_q           <= '0;
         rem_q           <= '0;
         cnt_q           <= '0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_acc) begin
                  dvd_q <= bus.dividend;
                  dsr_q <= bus.divisor;
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (dsr_q == '0) begin
                  bus.quotient    <= '1;
                  bus.remainder   <= dvd_q;
                  bus.div_by_zero <= 1'b1;
                  state           <= ST_DONE;
               end else begin
                  rem_q <= '0;
                  cnt_q <= CW'(WIDTH - 1);
                  state <= ST_ITER;
               end
            end
            ST_ITER: begin
               rem_q <= rem_nx;
               dvd_q <= WIDTH'({dvd_q, q_bit});
               cnt_q <= cnt_q - CW'(1);
               // last iteration: publish including the bit produced this cycle
               if (cnt_q == '0) begin
                  bus.quotient    <= WIDTH'({dvd_q, q_bit});
                  bus.remainder   <= WIDTH'(rem_nx);
                  bus.div_by_zero <= 1'b0;
                  state           <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = (state != ST_IDLE);
   assign bus.done = (state == ST_DONE);
endmodule

// File: doc/shift_sub_divider.md
SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk_100MHz  input  1  system clock, rising-edge active.
REQ-003 SHALL have port reset_butt  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a division; level-sensitive by default.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned numerator.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned denominator.
REQ-007 SHALL have port quotient  output  WIDTH  registered result.
REQ-008 SHALL have port remainder  output  WIDTH  registered result.
REQ-009 SHALL have port busy  output  1  high while a division is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-011 SHALL have port div_by_zero  output  1  registered flag, valid with done.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, ITER, DONE.
REQ-013 SHALL accept start only in IDLE; on the accepting edge it registers dividend and divisor and moves to LOAD.
REQ-014 SHALL ignore start in LOAD, ITER and DONE; operand inputs may change after acceptance without effect.
REQ-015 SHALL, in LOAD, go to DONE if divisor==0; otherwise clear the WIDTH+1-bit partial remainder, load the iteration counter with WIDTH-1, and go to ITER.
REQ-016 SHALL, per ITER cycle, shift {partial remainder, dividend MSB} left by one; if result >= divisor, subtract divisor and shift in quotient bit 1, else shift in 0 (restoring algorithm).
REQ-017 SHALL leave ITER for DONE after exactly WIDTH iterations; counter decrements once per iteration.
REQ-018 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-019 SHALL give latency from accepting edge to done high of WIDTH+2 cycles for nonzero divisor (10 for WIDTH=8) and 2 cycles for zero divisor.
REQ-020 SHALL assert busy in LOAD, ITER and DONE, and deassert it in IDLE.
REQ-021 SHALL update quotient, remainder and div_by_zero only on entry to DONE, and hold them until the next entry to DONE.
REQ-022 SHALL, for divisor==0, produce quotient all-ones, remainder=dividend and div_by_zero=1.
REQ-023 SHALL clear div_by_zero on the next division that has a nonzero divisor.
REQ-024 SHALL, if start is still high in IDLE after DONE, accept it on that IDLE edge, giving back-to-back divisions.

Reset
REQ-025 SHALL, on reset_butt high, immediately force IDLE and clear quotient, remainder, busy, done, div_by_zero and all internal registers, regardless of clock.
REQ-026 SHALL abandon an in-progress division on reset, with no done pulse; start is ignored while reset is high.

Configuration
REQ-027 SHALL, with macro DIV_START_EDGE_EN defined, accept start only on its rising edge (one accepted division per press); a start held high through DONE SHALL NOT retrigger.
REQ-028 SHALL, without DIV_START_EDGE_EN, use level-sensitive start per REQ-013/REQ-024.

Structure
REQ-029 SHALL take the state encoding (IDLE, LOAD, ITER, DONE) and the default WIDTH constant from shared package div_pkg.
REQ-030 SHALL implement the rising-edge detector of REQ-027 as sub-module start_pulse (registered previous level, reset to 0), instantiated only when DIV_START_EDGE_EN is defined.

Verification
REQ-031 SHALL cover: 100/7 -> quotient=14, remainder=2, div_by_zero=0, done exactly 10 cycles after acceptance, busy high 10 cycles.
REQ-032 SHALL cover: 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5.
REQ-033 SHALL cover: 42/0 -> quotient=255, remainder=42, div_by_zero=1, done 2 cycles after acceptance; then 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-034 SHALL cover: start 100/7, then drive start with 200/10 during ITER -> result still 14 r2 and no second done.
REQ-035 SHALL cover: reset_butt pulsed mid-ITER, asynchronous to the clock -> outputs 0 immediately, no done, next 100/7 correct.
REQ-036 SHALL cover: start held high for 30 cycles -> repeated done every 11 cycles without the macro; exactly one done with DIV_START_EDGE_EN.
